// File: rtl/worker_arb_pkg.sv
// Shared types and defaults for the worker round-robin arbiter.
//   arb_state_t         : arbiter FSM state encoding
//   DEFAULT_TIMEOUT_CYC : default watchdog limit, in cycles
package worker_arb_pkg;

    typedef enum logic [1:0] {
        A_IDLE    = 2'b00,
        A_RUN     = 2'b01,
        A_RELEASE = 2'b10
    } arb_state_t;

    localparam int unsigned DEFAULT_TIMEOUT_CYC = 15;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after pointer p,
// wrapping from N_REQ-1 back to 0.
//   req    : request vector
//   p      : search start index
//   win    : one-hot winner (0 when nothing requests)
//   win_id : index of the winner
//   any    : at least one request is set
module rr_pick #(
    parameter int unsigned  N_REQ = 4,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  p,
    output logic [N_REQ-1:0] win,
    output logic [ID_W-1:0]  win_id,
    output logic             any
);

    logic [ID_W:0] idx;
    logic          found;

    // Walk the N_REQ positions starting at p; the first set bit wins.
    always_comb begin
        win    = '0;
        win_id = '0;
        found  = 1'b0;
        idx    = '0;
        any    = |req;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = {1'b0, p} + (ID_W + 1)'(k);
            if (idx >= (ID_W + 1)'(N_REQ)) begin
                idx = idx - (ID_W + 1)'(N_REQ);
            end
            if (!found && req[ID_W'(idx)]) begin
                found             = 1'b1;
                win[ID_W'(idx)]   = 1'b1;
                win_id            = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/worker_arbiter.sv
// Round-robin front end that shares one start/busy/done worker between
// N_REQ requesters. One grant at a time; the worker's start is held through
// its full cycle, then the winner gets a one-cycle ack.
// Optional watchdog: define WORKER_ARB_TIMEOUT_EN to abort a job whose
// worker has not signalled done within TIMEOUT_CYC cycles.
//   clk, rst_n   : clock, async active-low reset
//   req          : level request per requester
//   gnt, gnt_id  : one-hot grant and index of current/last grantee
//   ack          : one-cycle pulse on the granted bit when its job ends
//   active       : arbiter is not idle
//   timeout_err  : one-cycle pulse on a watchdog abort (0 when compiled out)
//   worker_start : worker start line
//   worker_done  : worker done line
module worker_arbiter
    import worker_arb_pkg::*;
#(
    parameter int unsigned  N_REQ       = 4,
    parameter int unsigned  TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    localparam int unsigned ID_W        = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic [N_REQ-1:0] ack,
    output logic             active,
    output logic             timeout_err,
    output logic             worker_start,
    input  logic             worker_done
);

    arb_state_t       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_d, ack_d;
    logic [ID_W-1:0]  gnt_id_d;
    logic             start_d, active_d;

    logic [N_REQ-1:0] win;
    logic [ID_W-1:0]  win_id;
    logic             any;

`ifdef WORKER_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYC);
    assign timeout_err        = 1'b0;
`endif

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .p      (ptr_q),
        .win    (win),
        .win_id (win_id),
        .any    (any)
    );

    // State, pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= A_IDLE;
            ptr_q        <= '0;
            gnt          <= '0;
            gnt_id       <= '0;
            ack          <= '0;
            active       <= 1'b0;
            worker_start <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt          <= gnt_d;
            gnt_id       <= gnt_id_d;
            ack          <= ack_d;
            active       <= active_d;
            worker_start <= start_d;
        end
    end

`ifdef WORKER_ARB_TIMEOUT_EN
    // Watchdog counter and abort pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            timeout_err <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            timeout_err <= to_d;
        end
    end
`endif

    // Next-state and next-output decode.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt;
        gnt_id_d = gnt_id;
        ack_d    = '0;
        start_d  = worker_start;
`ifdef WORKER_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        to_d     = 1'b0;
`endif
        unique case (state_q)
            A_IDLE: begin
                gnt_d   = '0;
                start_d = 1'b0;
                // A worker still showing done is stale: hold off granting.
                if (any && !worker_done) begin
                    gnt_d    = win;
                    gnt_id_d = win_id;
                    start_d  = 1'b1;
                    ptr_d    = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + ID_W'(1);
                    state_d  = A_RUN;
`ifdef WORKER_ARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            A_RUN: begin
                start_d = 1'b1;
                if (worker_done) begin
                    start_d = 1'b0;
                    ack_d   = gnt;
                    state_d = A_RELEASE;
                end
`ifdef WORKER_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    start_d = 1'b0;
                    ack_d   = gnt;
                    to_d    = 1'b1;
                    state_d = A_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            A_RELEASE: begin
                start_d = 1'b0;
                if (!worker_done) begin
                    gnt_d   = '0;
                    state_d = A_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                start_d = 1'b0;
                state_d = A_IDLE;
            end
        endcase
        active_d = (state_d != A_IDLE);
    end

endmodule

// File: tb/tb_worker_arbiter.sv
// Self-checking bench for worker_arbiter: behavioural worker, transaction-level
// reference model compared every cycle, plus directed literal expectations.
// Define WORKER_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_worker_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 15;
    localparam int unsigned IW = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [N-1:0]  req   = '0;
    logic [N-1:0]  gnt, ack;
    logic [IW-1:0] gnt_id;
    logic          active, timeout_err, worker_start, worker_done;

    worker_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .gnt          (gnt),
        .gnt_id       (gnt_id),
        .ack          (ack),
        .active       (active),
        .timeout_err  (timeout_err),
        .worker_start (worker_start),
        .worker_done  (worker_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Worker: IDLE -start-> WORK -> DONE -(start low)-> IDLE; done = in DONE.
    int   wst        = 0;
    logic stuck_done = 1'b0;
    logic wstall     = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wst <= 0;
        else case (wst)
            0: if (worker_start) wst <= 1;
            1: if (!wstall) wst <= 2;
            default: if (!worker_start) wst <= 0;
        endcase
    end
    assign worker_done = (wst == 2) || stuck_done;

    // Reference model: phase 0 = idle, 1 = job running, 2 = waiting for done to fall.
    int           m_phase = 0, m_owner = 0, m_ptr = 0, m_id = 0, m_run = 0;
    logic [N-1:0] m_ack = '0;
    logic         m_to  = 1'b0;
    logic         m_d;
    logic [N-1:0] m_r;
    bit           m_found;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_owner = 0; m_ptr = 0; m_id = 0; m_run = 0;
            m_ack = '0; m_to = 1'b0;
        end else begin
            m_d = worker_done;
            m_r = req;
            m_ack = '0;
            m_to  = 1'b0;
            if (m_phase == 0) begin
                if (m_r != 0 && !m_d) begin
                    m_found = 0;
                    for (int k = 0; k < N; k++) begin
                        if (!m_found && m_r[(m_ptr + k) % N]) begin
                            m_found = 1;
                            m_owner = (m_ptr + k) % N;
                        end
                    end
                    m_id    = m_owner;
                    m_ptr   = (m_owner + 1) % N;
                    m_phase = 1;
                    m_run   = 0;
                end
            end else if (m_phase == 1) begin
                if (m_d) begin
                    m_ack[m_owner] = 1'b1;
                    m_phase = 2;
                end
`ifdef WORKER_ARB_TIMEOUT_EN
                else begin
                    m_run++;
                    if (m_run == TO) begin
                        m_ack[m_owner] = 1'b1;
                        m_to    = 1'b1;
                        m_phase = 2;
                    end
                end
`endif
            end else if (!m_d) begin
                m_phase = 0;
            end
        end
    end

    // Per-cycle compare against the model.
    bit           chk_en = 0;
    logic [N-1:0] e_gnt;
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            e_gnt = (m_phase != 0) ? (N'(1) << m_owner) : '0;
            check("gnt",          32'(gnt),          32'(e_gnt));
            check("gnt_id",       32'(gnt_id),       32'(m_id));
            check("ack",          32'(ack),          32'(m_ack));
            check("active",       32'(active),       32'(m_phase != 0));
            check("worker_start", 32'(worker_start), 32'(m_phase == 1));
            check("timeout_err",  32'(timeout_err),  32'(m_to));
            check("gnt_onehot",   32'($countones(gnt) <= 1), 32'd1);
        end
    end

    // Grant log: index and cycle of every rising grant.
    int           cyc = 0;
    int           glog_id[$];
    int           glog_cyc[$];
    logic [N-1:0] prev_gnt = '0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (rst_n && gnt != 0 && prev_gnt == 0) begin
            glog_id.push_back(int'(gnt_id));
            glog_cyc.push_back(cyc);
        end
        prev_gnt = rst_n ? gnt : '0;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grants(input int n, input int budget, input string name);
        int b = 0;
        while (glog_id.size() < n && b < budget) begin
            tick();
            b++;
        end
        check(name, 32'(glog_id.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int b = 0;
        while (active && b < budget) begin
            tick();
            b++;
        end
        check(name, 32'(active), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    int exp_ord1[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_ord2[4] = '{2, 3, 0, 1};

    initial begin
        // Reset with every requester asserting.
        req = 4'b1111;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_gnt",    32'(gnt), 0);
        check("rst_gnt_id", 32'(gnt_id), 0);
        check("rst_ack",    32'(ack), 0);
        check("rst_active", 32'(active), 0);
        check("rst_to",     32'(timeout_err), 0);
        check("rst_start",  32'(worker_start), 0);
        chk_en = 1;
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("first_gnt",    32'(gnt), 32'b0001);
        check("first_gnt_id", 32'(gnt_id), 0);
        check("first_start",  32'(worker_start), 1);

        // All requesting: eight jobs in strict rotation, 6 cycles apart.
        wait_grants(8, 200, "rr8_budget");
        req = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < glog_id.size()) begin
                check($sformatf("rr8_order%0d", k), 32'(glog_id[k]), 32'(exp_ord1[k]));
                if (k > 0)
                    check($sformatf("rr8_spacing%0d", k), 32'(glog_cyc[k] - glog_cyc[k-1]), 32'd6);
            end
        end
        wait_idle(50, "rr8_idle");

        // Single requester 2: grant at edge 1, ack after edge 4 only, idle after edge 6.
        tick();
        req = 4'b0100;
        tick();
        check("r2_gnt", 32'(gnt), 32'b0100);
        check("r2_id",  32'(gnt_id), 2);
        tick(); check("r2_ack_e2", 32'(ack), 0);
        tick(); check("r2_ack_e3", 32'(ack), 0);
        tick(); check("r2_ack_e4", 32'(ack), 32'b0100);
        req = '0;
        tick();
        check("r2_ack_e5",    32'(ack), 0);
        check("r2_active_e5", 32'(active), 1);
        tick();
        check("r2_active_e6", 32'(active), 0);
        check("r2_gnt_e6",    32'(gnt), 0);
        check("r2_id_hold",   32'(gnt_id), 2);

        // Requester 1 drops mid-job; job still completes with an ack.
        req = 4'b0010;
        tick();
        check("r1_gnt", 32'(gnt), 32'b0010);
        req = '0;
        tick(); tick(); tick();
        check("r1_ack", 32'(ack), 32'b0010);
        wait_idle(20, "r1_idle");
        glog_id.delete();
        glog_cyc.delete();
        req = 4'b1111;
        wait_grants(4, 100, "rr4_budget");
        req = '0;
        for (int k = 0; k < 4; k++)
            if (k < glog_id.size())
                check($sformatf("rr4_order%0d", k), 32'(glog_id[k]), 32'(exp_ord2[k]));
        wait_idle(50, "rr4_idle");

        // Stale done from the worker blocks granting.
        stuck_done = 1'b1;
        req = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stale_no_gnt", 32'(active), 0);
        end
        stuck_done = 1'b0;
        tick();
        check("stale_then_gnt", 32'(gnt), 32'b0100);
        req = '0;
        wait_idle(20, "stale_idle");

        // Reset mid-job at edge 3; next grant restarts from requester 0.
        req = 4'b1111;
        tick();
        check("mr_gnt", 32'(gnt), 32'b1000);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mr_start",  32'(worker_start), 0);
        check("mr_gnt0",   32'(gnt), 0);
        check("mr_active", 32'(active), 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("mr_next_gnt", 32'(gnt), 32'b0001);
        req = '0;
        wait_idle(20, "mr_idle");

`ifdef WORKER_ARB_TIMEOUT_EN
        // Worker never finishes: abort 15 cycles after grant, then serve the next.
        wstall = 1'b1;
        req = 4'b0011;
        tick();
        check("to_gnt", 32'(gnt), 32'b0010);
        repeat (14) tick();
        check("to_early_ack", 32'(ack), 0);
        check("to_early_err", 32'(timeout_err), 0);
        tick();
        check("to_err", 32'(timeout_err), 1);
        check("to_ack", 32'(ack), 32'b0010);
        req[1] = 1'b0;
        tick();
        check("to_err_pulse", 32'(timeout_err), 0);
        tick();
        check("to_next_gnt", 32'(gnt), 32'b0001);
        req = '0;
        wstall = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick();
`endif

        // Randomised requesters obeying the hold-until-ack rule.
        for (int c = 0; c < 800; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (req[i] && ack[i])
                    req[i] = 1'b0;
                else if (req[i] && gnt[i] && $urandom_range(0, 15) == 0)
                    req[i] = 1'b0;
                else if (!req[i] && !gnt[i] && $urandom_range(0, 2) == 0)
                    req[i] = 1'b1;
            end
        end
        req = '0;
        wait_idle(50, "rand_idle");
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/worker_arbiter.md
# worker_arbiter

Round-robin controller that shares one start/busy/done worker FSM between `N_REQ` requesters. It accepts level requests, grants one requester at a time, and drives the worker's `start` line through a full IDLE→WORK→DONE→IDLE cycle. It then acknowledges the winner and moves on to the next. It sits directly in front of the worker FSM, and both share `clk`/`rst_n`.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `TIMEOUT_CYC`, default 15: watchdog limit in cycles. Used only with `WORKER_ARB_TIMEOUT_EN`.
- `ID_W`, derived localparam `$clog2(N_REQ)`: width of `gnt_id`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in N_REQ: level request per requester.
- `gnt` out N_REQ: one-hot grant, held for the whole job.
- `gnt_id` out ID_W: index of the current/last grantee.
- `ack` out N_REQ: one-cycle pulse on the granted bit when its job ends.
- `active` out 1: high whenever the arbiter is not in A_IDLE.
- `timeout_err` out 1: one-cycle pulse on a watchdog abort. Tied 0 when the feature is compiled out.
- `worker_start` out 1: drives the worker's `start`.
- `worker_done` in 1: the worker's `done`.

## Operation
- All outputs are registered.
- Reset values: `gnt`=0, `gnt_id`=0, `ack`=0, `active`=0, `timeout_err`=0, `worker_start`=0, state=A_IDLE, RR pointer=0.
- States:
  - **A_IDLE**: if `req`≠0 and `worker_done`=0, select a winner, set `gnt`/`gnt_id`, set `worker_start`=1, go to A_RUN. If `worker_done`=1 (stale worker), stay and grant nothing.
  - **A_RUN**: hold `worker_start`=1. On sampled `worker_done`=1: `worker_start`←0, pulse `ack[gnt_id]`, go to A_RELEASE.
  - **A_RELEASE**: `worker_start`=0. On sampled `worker_done`=0: clear `gnt`, go to A_IDLE.
- Round-robin selection:
  - Search starts at pointer p, wrapping from N_REQ-1 to 0.
  - On grant, p←(winner+1) mod N_REQ.
  - After reset, `req[0]` has top priority.
- Requester rules:
  - Hold `req` until `ack`.
  - Deassert `req` the cycle after `ack`; a still-high `req` is treated as a new request.
  - Dropping `req` mid-job does not abort the job. It completes and `ack` still pulses.
- `gnt_id` holds its last value in A_IDLE; `gnt` is 0 there.
- Asynchronous reset mid-job returns everything to reset values immediately. The worker is reset by the same `rst_n`.
- Unknown/illegal state encodings decode to A_IDLE.

## Timing
- Edge numbering: edge 1 samples `req` in A_IDLE.
- Edge 1: `gnt`, `worker_start`, `active` go high.
- Edge 2: worker enters WORK (`busy`=1).
- Edge 3: worker enters DONE (`worker_done`=1).
- Edge 4: arbiter samples done. `ack` is high for the cycle after edge 4, and `worker_start`=0.
- Edge 5: worker returns to IDLE (done=0).
- Edge 6: arbiter samples done=0 and returns to A_IDLE. `gnt` and `active` clear.
- Edge 7: earliest next grant.
- Latency: req→gnt is 1 cycle, gnt→ack is 3 cycles. Back-to-back grant spacing is 6 cycles.
- Fairness: with all `req` high, the grant order is 0,1,…,N_REQ-1,0,…
- A `req` rising in the same cycle the arbiter leaves A_RELEASE is eligible at the next A_IDLE sample.

## Configuration
- Macro: `WORKER_ARB_TIMEOUT_EN`.
- Defined:
  - A cycle counter clears on entry to A_RUN and increments each A_RUN cycle.
  - If it reaches `TIMEOUT_CYC` with `worker_done` still 0: `worker_start`←0, pulse `timeout_err` and `ack[gnt_id]` together, go to A_RELEASE.
  - The RR pointer advances as normal.
- Not defined: no counter, `timeout_err` tied 0, and A_RUN waits indefinitely.

## Structure
- Package `worker_arb_pkg` holds:
  - the state typedef `arb_state_t` with A_IDLE=2'b00, A_RUN=2'b01, A_RELEASE=2'b10;
  - the `DEFAULT_TIMEOUT_CYC` constant.
- One sub-module, `rr_pick`: combinational, taking `req`, pointer `p` → one-hot `win`, `win_id`, `any`. It is unit-testable on its own.
- The top level holds the FSM, pointer, watchdog and output registers.

## Test plan
- Reset with `req`=4'b1111 held low-active → all outputs 0. First grant after release is `gnt`=4'b0001, `gnt_id`=0.
- Single `req[2]` pulse held to `ack` → `gnt`=4'b0100 on edge 1, `ack`=4'b0100 for exactly one cycle after edge 4, `active` low after edge 6.
- `req`=4'b1111 for 8 jobs → grant order 0,1,2,3,0,1,2,3, spaced 6 cycles, never two `gnt` bits high.
- `req[1]` dropped in A_RUN → job completes and `ack[1]` pulses. `req[1]` re-raised after `ack` → served after the others.
- `rst_n` asserted at edge 3 of a job → `worker_start`, `gnt`, `active` drop immediately. The next grant is to `req[0]` if requesting.
- With `WORKER_ARB_TIMEOUT_EN` and `TIMEOUT_CYC`=15, worker model never asserting done → `timeout_err` and `ack` pulse 15 cycles after grant, then the next requester is granted.
